// File: rtl/demux_route_ctrl_if.sv
// Stream bundle for demux_route_ctrl: one input stream,
// N valid/ready output channels sharing a data bus.
interface demux_route_ctrl_if #(
  parameter int N     = 16,
  parameter int SEL_W = 4,
  parameter int DW    = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [SEL_W-1:0] in_sel;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [DW-1:0]    out_data;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_route_ctrl.sv
// Sequencing controller for a 1:N demux: addressed or
// round-robin steering with a per-word drop timeout.
module demux_route_ctrl #(
  parameter int N       = 16,
  parameter int SEL_W   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  demux_route_ctrl_if.slave bus,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
  output logic             drop,
  output logic [SEL_W-1:0] rr_ptr
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_q, rr_d, rr_inc;
  logic             scan_q, scan_d;
  logic             drop_q, drop_d;
  logic [N-1:0]     onehot;
  logic             rdy_sel;
  logic             xfer;
  logic             tmo;
  logic             accept;
  logic             illegal;
  logic [SEL_W-1:0] dest;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++)
      onehot[i] = (sel_q == SEL_W'(i));
  end

  // sel_q only ever holds a legal channel
  assign rdy_sel = |(bus.out_ready & onehot);
  assign rr_inc  = (rr_q == SEL_W'(N - 1)) ? '0 : rr_q + 1'b1;
  assign illegal = ~mode & (32'(bus.in_sel) >= 32'(N));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    scan_d  = scan_q;
    drop_d  = 1'b0;
    xfer    = 1'b0;
    tmo     = 1'b0;
    bus.in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = rst_n;
      end
      SEND: begin
        xfer = rdy_sel;
        tmo  = ~rdy_sel & (cnt_q == 16'(TIMEOUT - 1));
        bus.in_ready = rst_n & rdy_sel
                     & (cnt_q < 16'(TIMEOUT - 1));
        if (xfer | tmo) begin
          state_d = IDLE;
          if (scan_q) rr_d = rr_inc;
          if (tmo) drop_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
    accept = bus.in_valid & bus.in_ready;
    // a scan word taken on a transfer uses the advanced pointer
    dest = mode ? rr_d : bus.in_sel;
    if (accept) begin
      if (illegal) begin
        drop_d = 1'b1;
      end else begin
        state_d = SEND;
        data_d  = bus.in_data;
        sel_d   = dest;
        scan_d  = mode;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      scan_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      scan_q  <= scan_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.out_valid = (state_q == SEND) ? onehot : '0;
  assign bus.out_data  = data_q;
  assign cur_sel       = sel_q;
  assign busy          = (state_q == SEND);
  assign drop          = drop_q;
  assign rr_ptr        = rr_q;

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Sequencing controller in front of the 1:N demux datapath.
- Accepts words on a single valid/ready input stream. Steers each word to exactly one of N output channels, each with its own valid/ready handshake.
- Destination is either the per-word select (addressed mode) or an internal round-robin pointer (scan mode).
- A per-word timeout drops words that a stalled channel never accepts, so one dead channel cannot block the stream.

Parameters:
- N, 16, number of output channels (2..256).
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N.
- DW, 8, data word width.
- TIMEOUT, 64, cycles a word waits on its channel before being dropped (1..65535).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = addressed (use in_sel), 1 = round-robin scan.
- in_valid  input  1  input word valid.
- in_ready  output  1  controller can accept a word.
- in_data  input  DW  input word.
- in_sel  input  SEL_W  destination channel in addressed mode.
- out_valid  output  N  one-hot (or zero) per-channel valid.
- out_ready  input  N  per-channel ready.
- out_data  output  DW  word, shared by all channels.
- cur_sel  output  SEL_W  channel currently driven; the demux select.
- busy  output  1  a word is held.
- drop  output  1  one-cycle pulse when a word is discarded.
- rr_ptr  output  SEL_W  current round-robin pointer.

Behaviour:
- Reset: sampled on clk when rst_n=0, and overrides everything, including mid-transfer. Next-state values:
  - state=IDLE; out_valid=0; out_data=0; cur_sel=0; rr_ptr=0.
  - busy=0; drop=0; timeout counter=0.
  - in_ready=0 while rst_n=0; in_ready=1 the first cycle after release.
  - A held word is lost silently; drop is not pulsed.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready:
    - Latch in_data into out_data.
    - Latch destination into cur_sel: mode=1 -> rr_ptr, mode=0 -> in_sel.
    - Clear the counter and go to SEND.
  - mode is sampled only at acceptance; changing it while in SEND has no effect on the held word.
- Illegal select: addressed mode with in_sel >= N.
  - The word is accepted and dropped in the same edge.
  - drop=1 next cycle; state stays IDLE; no out_valid.
- SEND:
  - busy=1; out_valid = one-hot at cur_sel; out_data and cur_sel stable until transfer or drop.
  - Transfer occurs when out_ready[cur_sel]=1. out_ready on other channels is ignored.
- In SEND, in_ready = out_ready[cur_sel] & (counter < TIMEOUT-1). This combinational path allows back-to-back words.
- On transfer in the same cycle as in_valid: the new word is latched directly, state stays SEND, and there is no idle bubble.
  - Sustained throughput is 1 word/cycle into a ready channel.
- On transfer without a new word: go to IDLE; out_valid=0 next cycle.
- Round-robin advance:
  - In scan mode, rr_ptr advances by 1 on each transfer or timeout drop of a scan-mode word.
  - Wrap N-1 -> 0.
  - rr_ptr never changes in addressed mode.
- Timeout:
  - The counter increments each SEND cycle without a transfer.
  - When the counter reaches TIMEOUT-1 without out_ready: the word is discarded, out_valid is cleared, drop=1 for one cycle, and state returns to IDLE.
  - A transfer on that same cycle wins; no drop.
- Latency: accepted word appears on out_valid the cycle after acceptance.

Test Plan:
- Addressed sweep: mode=0, all out_ready=1, in_sel=0..15 with in_data=8'hA0+i, back-to-back -> each out_valid[i] high exactly one cycle with out_data=A0+i; 16 words in 17 cycles; drop never asserted.
- Scan mode: mode=1, in_valid held, 20 words, all ready -> channels 0..15 then 0..3 in order; rr_ptr=4 at end.
- Backpressure and timeout: mode=0, in_sel=5, out_ready[5]=0 -> out_valid[5] held 64 cycles, then drop pulses once, state IDLE. Repeat with out_ready[5] raised on cycle 63 -> transfer, no drop.
- Wrong-channel ready: out_ready=16'hFFDF while cur_sel=5 -> no transfer, in_ready=0 until out_ready[5]=1.
- Reset mid-SEND: assert rst_n=0 during SEND with out_valid[7]=1 -> next cycle out_valid=0, busy=0, rr_ptr=0, drop=0; first word after release goes to the correct channel.
- N=12 build, in_sel=13 -> drop pulse one cycle after acceptance, no out_valid bit set.
